// File: rtl/mclk_pkg.sv
// Shared types and limits for the machine clock pulse source (mclk_gen).
package mclk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    INHIB = 2'd3
  } mclk_state_t;

  localparam int MCLK_PERIOD_MIN = 2;

  function automatic logic st_busy(input mclk_state_t st);
    return (st != IDLE);
  endfunction

endpackage

// File: rtl/mclk_gen_tmr.sv
// Loadable period down-counter for mclk_gen; saturates at zero and reports it.
module mclk_tmr
  import mclk_pkg::*;
#(
  parameter int PERIOD = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic enable,
  output logic zero
);

  localparam int W = $clog2(PERIOD);
  localparam logic [W-1:0] ZERO_VAL = W'(0);
  localparam logic [W-1:0] ONE_VAL  = W'(1);
  localparam logic [W-1:0] LOAD_VAL = W'(PERIOD - 1);

  logic [W-1:0] cnt_r;

  // Period counter: clear wins over load; a zero count holds until reloaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= ZERO_VAL;
    end else if (clr) begin
      cnt_r <= ZERO_VAL;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (enable && (cnt_r != ZERO_VAL)) begin
      cnt_r <= cnt_r - ONE_VAL;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == ZERO_VAL);

endmodule

// File: rtl/mclk_gen.sv
// Machine clock pulse source: run/step/stop control with hold stretch.
// Optional pulse counter output pcnt when MCLK_PCNT_EN is defined.
module mclk_gen
  import mclk_pkg::*;
#(
  parameter int PERIOD = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        stop,
  input  logic        hold,
  output logic        p,
  output logic        running,
  output logic        busy
`ifdef MCLK_PCNT_EN
  ,
  output logic [15:0] pcnt
`endif
);

  if (PERIOD < MCLK_PERIOD_MIN) begin : g_bad_period
    $error("mclk_gen: PERIOD must be at least 2");
  end

  mclk_state_t state_r;
  mclk_state_t state_nxt_s;
  logic        fire_s;
  logic        clr_s;
  logic        zero_s;
  logic        enable_s;
  logic        stepped_r;
  logic        stepped_nxt_s;
  logic        p_r;
  logic        running_r;
  logic        busy_r;

  assign enable_s = !hold;

  mclk_tmr #(
    .PERIOD(PERIOD)
  ) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_s),
    .load   (fire_s),
    .enable (enable_s),
    .zero   (zero_s)
  );

  // Next state and tick decision; a zero count held off by hold stays pending.
  always_comb begin
    state_nxt_s = state_r;
    fire_s      = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        clr_s = 1'b1;
        if (stop) begin
          state_nxt_s = run ? INHIB : IDLE;
        end else if (run) begin
          state_nxt_s = RUN;
        end else if (step) begin
          state_nxt_s = STEP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          clr_s       = 1'b1;
          state_nxt_s = run ? INHIB : IDLE;
        end else if (!run) begin
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (zero_s && !hold) begin
          fire_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STEP: begin
        if (stop) begin
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (!stepped_r) begin
          if (zero_s && !hold) begin
            fire_s = 1'b1;
          end else begin
            fire_s = 1'b0;
          end
          state_nxt_s = STEP;
        end else if (zero_s) begin
          clr_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STEP;
        end
      end
      INHIB: begin
        clr_s = 1'b1;
        if (!run) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = INHIB;
        end
      end
      default: begin
        clr_s       = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
    stepped_nxt_s = (state_nxt_s == STEP) && (stepped_r || fire_s);
  end

  // State register and registered outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      stepped_r <= 1'b0;
      p_r       <= 1'b0;
      running_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      stepped_r <= stepped_nxt_s;
      p_r       <= fire_s;
      running_r <= (state_nxt_s == RUN);
      busy_r    <= st_busy(state_nxt_s);
    end
  end

  assign p       = p_r;
  assign running = running_r;
  assign busy    = busy_r;

`ifdef MCLK_PCNT_EN
  logic [15:0] pcnt_r;

  // Pulse counter: counts in the cycle after each p and wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_r <= 16'd0;
    end else if (p_r) begin
      pcnt_r <= pcnt_r + 16'd1;
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

  assign pcnt = pcnt_r;
`endif

endmodule
